// File: rtl/spfp_addsub_arbiter.sv
// rtl/spfp_addsub_arbiter.sv - two-requester arbiter/sequencer for the shared SPFP add/sub datapath
// Optional SPFP_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (requester 0 wins).
module spfp_addsub_arbiter #(
    parameter int unsigned ADDER_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_n1,
    input  logic [31:0] req0_n2,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_n1,
    input  logic [31:0] req1_n2,
    input  logic        req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_z,
    output logic [31:0] n1,
    output logic [31:0] n2,
    output logic        add_or_sub,
    input  logic [31:0] z,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       gnt_id;
    logic       grant;

`ifdef SPFP_ARB_RR_EN
    // rr_ptr holds the ID preferred on the next tie, i.e. the one not granted last
    logic rr_ptr;

    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = rr_ptr;
        end else begin
            gnt_id = req1_valid;
        end
    end
`else
    always_comb begin
        gnt_id = 1'b0;
        gnt_id = !req0_valid;
    end
`endif

    assign req0_ready = (state == IDLE) && req0_valid && !gnt_id;
    assign req1_ready = (state == IDLE) && req1_valid && gnt_id;
    assign grant      = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            n1         <= 32'd0;
            n2         <= 32'd0;
            add_or_sub <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_z      <= 32'd0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
`ifdef SPFP_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        n1         <= gnt_id ? req1_n1 : req0_n1;
                        n2         <= gnt_id ? req1_n2 : req0_n2;
                        add_or_sub <= gnt_id ? req1_op : req0_op;
                        rsp_id     <= gnt_id;
                        cnt        <= 4'(ADDER_LAT);
                        busy       <= 1'b1;
                        state      <= WAIT;
`ifdef SPFP_ARB_RR_EN
                        rr_ptr     <= !gnt_id;
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_z     <= z;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // operands stay on n1/n2 so the datapath output remains stable
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spfp_addsub_arbiter.sv
// tb/tb_spfp_addsub_arbiter.sv - scoreboard bench for spfp_addsub_arbiter at ADDER_LAT 1 and 4
module tb_spfp_addsub_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_r0v, a_r0r, a_r0op, a_r1v, a_r1r, a_r1op, a_rspv, a_rspr, a_rspid, a_aos, a_busy;
    logic [31:0] a_r0n1, a_r0n2, a_r1n1, a_r1n2, a_rspz, a_n1, a_n2, a_z;
    logic        b_r0v, b_r0r, b_r0op, b_r1v, b_r1r, b_r1op, b_rspv, b_rspr, b_rspid, b_aos, b_busy;
    logic [31:0] b_r0n1, b_r0n2, b_r1n1, b_r1n2, b_rspz, b_n1, b_n2, b_z;

    // datapath stand-in: IEEE results for the known vectors, a bit-mixing function otherwise
    function automatic logic [31:0] fp_model(input logic [31:0] x, input logic [31:0] y, input logic op);
        if (x == 32'h3F800000 && y == 32'h40000000 && !op) return 32'h40400000;
        if (x == 32'h40A00000 && y == 32'h3F800000 && op)  return 32'h40800000;
        return x ^ {y[15:0], y[31:16]} ^ {31'd0, op} ^ 32'h5A5A0000;
    endfunction

    int b_hold;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_hold <= 0;
        else if ((b_r0v && b_r0r) || (b_r1v && b_r1r)) b_hold <= 0;
        else if (b_hold < 100) b_hold <= b_hold + 1;
    end

    assign a_z = fp_model(a_n1, a_n2, a_aos);
    assign b_z = (b_hold >= 3) ? fp_model(b_n1, b_n2, b_aos) : 32'hDEADBEEF;

    spfp_addsub_arbiter #(.ADDER_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_n1(a_r0n1), .req0_n2(a_r0n2), .req0_op(a_r0op),
        .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_n1(a_r1n1), .req1_n2(a_r1n2), .req1_op(a_r1op),
        .rsp_valid(a_rspv), .rsp_ready(a_rspr), .rsp_id(a_rspid), .rsp_z(a_rspz),
        .n1(a_n1), .n2(a_n2), .add_or_sub(a_aos), .z(a_z), .busy(a_busy)
    );

    spfp_addsub_arbiter #(.ADDER_LAT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_n1(b_r0n1), .req0_n2(b_r0n2), .req0_op(b_r0op),
        .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_n1(b_r1n1), .req1_n2(b_r1n2), .req1_op(b_r1op),
        .rsp_valid(b_rspv), .rsp_ready(b_rspr), .rsp_id(b_rspid), .rsp_z(b_rspz),
        .n1(b_n1), .n2(b_n2), .add_or_sub(b_aos), .z(b_z), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [32:0] sb[$];
    logic        id_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_r0v && a_r0r) sb.push_back({1'b0, fp_model(a_r0n1, a_r0n2, a_r0op)});
            if (a_r1v && a_r1r) sb.push_back({1'b1, fp_model(a_r1n1, a_r1n2, a_r1op)});
            if (a_rspv && a_rspr) begin
                id_log.push_back(a_rspid);
                chk("sb_not_empty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("sb_rsp", {31'd0, a_rspid, a_rspz}, {31'd0, sb.pop_front()});
            end
        end
    end

    task automatic wait_a(input string tag);
        int k;
        k = 0;
        while (!a_rspv && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_timeout"}, a_rspv, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int g0;
        int g1;
        int k;
        logic r1_seen;
        logic [31:0] z0;
        logic [31:0] n10;
        logic exp_id[4];

        {a_r0v, a_r0op, a_r1v, a_r1op} = '0;
        {b_r0v, b_r0op, b_r1v, b_r1op} = '0;
        {a_r0n1, a_r0n2, a_r1n1, a_r1n2} = '0;
        {b_r0n1, b_r0n2, b_r1n1, b_r1n2} = '0;
        a_rspr = 1'b1;
        b_rspr = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_ctrl", {a_r0r, a_r1r, a_rspv, a_rspid, a_aos, a_busy}, 0);
        chk("reset_a_data", {a_rspz, a_n1}, 0);
        chk("reset_a_n2", a_n2, 0);
        chk("reset_b_ctrl", {b_r0r, b_r1r, b_rspv, b_rspid, b_aos, b_busy, b_n1}, 0);
        @(negedge clk) rst_n = 1'b1;

        // contention: both valid for four operations
        @(posedge clk); #1;
        a_r0v = 1'b1; a_r0n1 = 32'h11112222; a_r0n2 = 32'h33334444; a_r0op = 1'b0;
        a_r1v = 1'b1; a_r1n1 = 32'h55556666; a_r1n2 = 32'h77778888; a_r1op = 1'b1;
        r1_seen = a_r1r;
        for (k = 0; k < 40 && id_log.size() < 4; k++) begin
            @(posedge clk); #1;
            if (a_r1r) r1_seen = 1'b1;
        end
        a_r0v = 1'b0; a_r1v = 1'b0;
`ifdef SPFP_ARB_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        chk("cont_r1_ready_seen", r1_seen, 1);
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
        chk("cont_r1_ready_seen", r1_seen, 0);
`endif
        chk("cont_count", id_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < id_log.size()) chk($sformatf("cont_id%0d", i), id_log[i], exp_id[i]);
        end
        @(posedge clk); #1;
        chk("cont_idle", a_busy, 0);

        // single add, latency 1
        a_r0v = 1'b1; a_r0n1 = 32'h3F800000; a_r0n2 = 32'h40000000; a_r0op = 1'b0;
        t = cyc;
        @(posedge clk); #1;
        a_r0v = 1'b0;
        wait_a("add");
        chk("add_rsp_cycle", cyc - t, 2);
        chk("add_rsp_z", a_rspz, 32'h40400000);
        chk("add_rsp_id", a_rspid, 0);
        @(posedge clk); #1;

        // backpressure while req1 waits
        a_rspr = 1'b0;
        a_r0v = 1'b1; a_r0n1 = 32'hCAFE0001; a_r0n2 = 32'h0BAD0002; a_r0op = 1'b1;
        @(posedge clk); #1;
        a_r0v = 1'b0;
        wait_a("bp");
        a_r1v = 1'b1; a_r1n1 = 32'h12345678; a_r1n2 = 32'h9ABCDEF0; a_r1op = 1'b0;
        z0 = fp_model(32'hCAFE0001, 32'h0BAD0002, 1'b1);
        n10 = 32'hCAFE0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", i), {a_rspv, a_r1r, a_rspz, a_n1}, {1'b1, 1'b0, z0, n10});
        end
        a_rspr = 1'b1;
        @(posedge clk); #1;
        chk("bp_r1_granted", a_r1r, 1);
        @(posedge clk); #1;
        a_r1v = 1'b0;
        chk("bp_busy", a_busy, 1);
        wait_a("bp_r1");
        chk("bp_r1_id", a_rspid, 1);
        @(posedge clk); #1;

        // reset mid-WAIT
        a_r0v = 1'b1; a_r0n1 = 32'h0F0F0F0F; a_r0n2 = 32'hF0F0F0F0; a_r0op = 1'b0;
        @(posedge clk); #1;
        a_r0v = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_mid_ctrl", {a_rspv, a_rspid, a_aos, a_busy, a_r0r, a_r1r}, 0);
        chk("rst_mid_data", {a_rspz, a_n1}, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_rsp", {a_rspv, a_busy}, 0);
        a_r1v = 1'b1; a_r1n1 = 32'h40A00000; a_r1n2 = 32'h3F800000; a_r1op = 1'b1;
        @(posedge clk); #1;
        a_r1v = 1'b0;
        wait_a("sub");
        chk("sub_rsp", {a_rspid, a_rspz}, {1'b1, 32'h40800000});
        @(posedge clk); #1;

        // latency sweep on the ADDER_LAT=4 instance
        b_r0v = 1'b1; b_r0n1 = 32'h3F800000; b_r0n2 = 32'h40000000; b_r0op = 1'b0;
        @(posedge clk); #1;
        b_r0v = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("lat4_hold%0d", i), {b_rspv, b_n1}, {1'b0, 32'h3F800000});
            @(posedge clk); #1;
        end
        chk("lat4_rsp", {b_rspv, b_rspid, b_rspz}, {1'b1, 1'b0, 32'h40400000});
        @(posedge clk); #1;
        b_r0v = 1'b1; b_r0n1 = 32'h01020304;
        g0 = -1; g1 = -1;
        for (k = 0; k < 30 && g1 < 0; k++) begin
            if (b_r0r) begin
                if (g0 < 0) g0 = cyc; else g1 = cyc;
            end
            @(posedge clk); #1;
        end
        b_r0v = 1'b0;
        chk("lat4_b2b_gap", g1 - g0, 6);

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
